tlb_assoc: RTL

- Parametrised fully-associative TLB; next generation of the 8-entry translation cache in the fetch/memory stages.
- Two combinational lookup ports: port 0 for fetch, port 1 for memory.
- Adds over the previous block: per-entry valid bits, a global-page bit, and write-hit update in place.
- Also adds: fill into invalid slots first, then round-robin eviction; a multi-cycle invalidate engine (flush all / flush PID / invalidate one page); an indexed debug read-back port.

---
 rtl/tlb_pkg.sv | 23 ++
 rtl/tlb_match.sv | 40 ++++
 rtl/tlb_assoc.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/tlb_pkg.sv
// Shared constants and types for the fully-associative TLB.
package tlb_pkg;

    localparam logic [7:0] EXC_NONE  = 8'h00;
    localparam logic [7:0] EXC_UMISS = 8'h82;
    localparam logic [7:0] EXC_KMISS = 8'h83;

    localparam logic [1:0] FLUSH_ALL  = 2'b00;
    localparam logic [1:0] FLUSH_PID  = 2'b01;
    localparam logic [1:0] INVAL_PAGE = 2'b10;

    typedef enum logic {IDLE, SCAN} state_t;

    // Entry layout at default widths (PID 12, VPN 20, PPN 6); matches rd_out ordering.
    typedef struct packed {
        logic        valid;
        logic        gbl;
        logic [11:0] pid;
        logic [19:0] vpn;
        logic [5:0]  ppn;
    } tlb_entry_t;

endpackage

// File: rtl/tlb_match.sv
// Combinational N-way tag matcher: one-hot hit vector plus lowest-index encode.
module tlb_match #(
    parameter int ENTRIES = 8,
    parameter int PID_W   = 12,
    parameter int VPN_W   = 20,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic [ENTRIES-1:0]            valid,
    input  logic [ENTRIES-1:0]            gbl,
    input  logic [ENTRIES-1:0][PID_W-1:0] pids,
    input  logic [ENTRIES-1:0][VPN_W-1:0] vpns,
    input  logic [PID_W-1:0]              key_pid,
    input  logic [VPN_W-1:0]              key_vpn,
    output logic [ENTRIES-1:0]            hit,
    output logic [IDX_W-1:0]              idx
);

    logic found;

    // Per-entry compare: valid, VPN equal, and either global or same PID.
    always_comb begin
        hit = '0;
        for (int unsigned i = 0; i < ENTRIES; i++) begin
            hit[i] = valid[i] && (vpns[i] == key_vpn) && (gbl[i] || (pids[i] == key_pid));
        end
    end

    // Priority encode: lowest hitting index wins.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < ENTRIES; i++) begin
            if (hit[i] && !found) begin
                idx   = IDX_W'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tlb_assoc.sv
// Fully-associative TLB with two lookup ports, fill/update, invalidate engine and debug read-back.
module tlb_assoc
    import tlb_pkg::*;
#(
    parameter int ENTRIES   = 8,
    parameter int PID_W     = 12,
    parameter int PAGE_BITS = 12,
    parameter int PPN_W     = 6,
    parameter int IDX_W     = $clog2(ENTRIES),
    parameter int VPN_W     = 32 - PAGE_BITS,
    parameter int PA_W      = PPN_W + PAGE_BITS
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          kmode,
    input  logic [PID_W-1:0]              pid,
    input  logic [31:0]                   addr0,
    input  logic [31:0]                   addr1,
    input  logic [7:0]                    exc_in,
    output logic [7:0]                    exc_out0,
    output logic [7:0]                    exc_out1,
    output logic [PA_W-1:0]               addr0_out,
    output logic [PA_W-1:0]               addr1_out,
    input  logic                          we,
    input  logic [PID_W-1:0]              wr_pid,
    input  logic [VPN_W-1:0]              wr_vpn,
    input  logic [31:0]                   wr_data,
    input  logic                          op_valid,
    input  logic [1:0]                    op_code,
    output logic                          busy,
    input  logic [IDX_W-1:0]              rd_index,
    output logic [PID_W+VPN_W+PPN_W+1:0]  rd_out
);

    logic [ENTRIES-1:0]            valid;
    logic [ENTRIES-1:0]            gbl;
    logic [ENTRIES-1:0][PID_W-1:0] pids;
    logic [ENTRIES-1:0][VPN_W-1:0] vpns;
    logic [ENTRIES-1:0][PPN_W-1:0] ppns;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] ptr_q;
    logic [1:0]       op_q;
    logic [PID_W-1:0] pid_q;
    logic [VPN_W-1:0] vpn_q;

    logic [ENTRIES-1:0] hit0, hit1, hitw;
    logic [IDX_W-1:0]   idx0, idx1, idxw;
    logic               any0, any1, anyw;
    logic [IDX_W-1:0]   inv_idx, target;
    logic               inv_any, fill_en, scan_clr, flush_all, start_scan;
    logic               unused_wr_data;

    assign unused_wr_data = ^wr_data[31:PPN_W+1];

    tlb_match #(.ENTRIES(ENTRIES), .PID_W(PID_W), .VPN_W(VPN_W), .IDX_W(IDX_W)) u_match0 (
        .valid(valid), .gbl(gbl), .pids(pids), .vpns(vpns),
        .key_pid(pid), .key_vpn(addr0[31:PAGE_BITS]), .hit(hit0), .idx(idx0));

    tlb_match #(.ENTRIES(ENTRIES), .PID_W(PID_W), .VPN_W(VPN_W), .IDX_W(IDX_W)) u_match1 (
        .valid(valid), .gbl(gbl), .pids(pids), .vpns(vpns),
        .key_pid(pid), .key_vpn(addr1[31:PAGE_BITS]), .hit(hit1), .idx(idx1));

    tlb_match #(.ENTRIES(ENTRIES), .PID_W(PID_W), .VPN_W(VPN_W), .IDX_W(IDX_W)) u_matchw (
        .valid(valid), .gbl(gbl), .pids(pids), .vpns(vpns),
        .key_pid(wr_pid), .key_vpn(wr_vpn), .hit(hitw), .idx(idxw));

    assign busy = (state_q == SCAN);
    assign any0 = (|hit0) && !busy;
    assign any1 = (|hit1) && !busy;
    assign anyw = |hitw;

    // Lookup outputs for both ports; busy forces a miss.
    always_comb begin
        addr0_out = any0 ? {ppns[idx0], addr0[PAGE_BITS-1:0]} : {{PPN_W{1'b0}}, addr0[PAGE_BITS-1:0]};
        addr1_out = any1 ? {ppns[idx1], addr1[PAGE_BITS-1:0]} : {{PPN_W{1'b0}}, addr1[PAGE_BITS-1:0]};
        exc_out0  = any0 ? EXC_NONE : (kmode ? EXC_KMISS : EXC_UMISS);
        exc_out1  = (exc_in != 8'h00) ? exc_in : (any1 ? EXC_NONE : (kmode ? EXC_KMISS : EXC_UMISS));
    end

    // Fill target: existing key, else lowest invalid, else round-robin victim.
    always_comb begin
        inv_idx = '0;
        inv_any = 1'b0;
        for (int unsigned i = 0; i < ENTRIES; i++) begin
            if (!valid[i] && !inv_any) begin
                inv_idx = IDX_W'(i);
                inv_any = 1'b1;
            end
        end
        target = anyw ? idxw : (inv_any ? inv_idx : ptr_q);
    end

    assign fill_en    = we && (state_q == IDLE) && !op_valid;
    assign flush_all  = (state_q == IDLE) && op_valid && (op_code == FLUSH_ALL);
    assign start_scan = (state_q == IDLE) && op_valid && ((op_code == FLUSH_PID) || (op_code == INVAL_PAGE));

    // Invalidate FSM next state and the clear decision for the entry under the scan counter.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        scan_clr = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_scan) begin
                    state_d = SCAN;
                    cnt_d   = '0;
                end
            end
            SCAN: begin
                if (op_q == FLUSH_PID)
                    scan_clr = valid[cnt_q] && !gbl[cnt_q] && (pids[cnt_q] == pid_q);
                else
                    scan_clr = valid[cnt_q] && (vpns[cnt_q] == vpn_q) && (gbl[cnt_q] || (pids[cnt_q] == pid_q));
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == IDX_W'(ENTRIES - 1))
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Control registers: FSM, scan counter, latched op, victim pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ptr_q   <= '0;
            op_q    <= FLUSH_ALL;
            pid_q   <= '0;
            vpn_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (start_scan) begin
                op_q  <= op_code;
                pid_q <= wr_pid;
                vpn_q <= wr_vpn;
            end
            if (fill_en && !anyw && !inv_any)
                ptr_q <= ptr_q + 1'b1;
        end
    end

    // Valid bits: reset, flush-all, scan clears and fills.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
        end else if (flush_all) begin
            valid <= '0;
        end else if (scan_clr) begin
            valid[cnt_q] <= 1'b0;
        end else if (fill_en) begin
            valid[target] <= 1'b1;
        end
    end

    // Key/value storage, written only by fills and never reset.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            gbl[target]  <= wr_data[PPN_W];
            pids[target] <= wr_pid;
            vpns[target] <= wr_vpn;
            ppns[target] <= wr_data[PPN_W-1:0];
        end
    end

    assign rd_out = {valid[rd_index], gbl[rd_index], pids[rd_index], vpns[rd_index], ppns[rd_index]};

endmodule
